// File: rtl/hazard_sched.sv
// -----------------------------------------------------------------------------
// hazard_sched
//
// Hazard scheduler for a five-stage pipeline. It keeps compact records of the
// instructions in E, M and W and uses them to decide two things:
//   * whether the instruction in D must stall. This happens when an operand it
//     needs is not ready in time, or when it touches a busy mult/div unit.
//   * where each stage should take its GRF operands from. The choice is the
//     register file / stage register, or a younger pipeline result.
//
// A stall freezes F/D and pushes a bubble into E. M and W always advance, so
// every outstanding producer drains on its own.
//
// Ports
//   clk                    pipeline clock, rising edge
//   reset                  synchronous reset, active low
//   d_valid                D holds a real instruction
//   d_rs, d_rt             D source register numbers
//   d_tuse_rs, d_tuse_rt   cycles until the operand is consumed (3 = unused)
//   d_dst                  D destination register (0 = no write)
//   d_tnew                 result latency at E entry (0 E, 1 M, 2 W)
//   d_md                   D instruction uses the mult/div unit
//   e_start, e_busy        mult/div start pulse and busy flag
//   stall                  freeze F/D, bubble E
//   D_GRF_r*_ForwardSrc    0 GRF, 1 M_CalcResult, 2 E_SetWordResult
//   E_GRF_r*_ForwardSrc    0 E reg, 1 W_RegData, 2 M_CalcResult
//   M_GRF_rt_ForwardSrc    0 M reg, 1 W_RegData
//   stall_cnt              saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  d_dst,
  input  logic [1:0]  d_tnew,
  input  logic        d_md,
  input  logic        e_start,
  input  logic        e_busy,
  output logic        stall,
  output logic [1:0]  D_GRF_rs_ForwardSrc,
  output logic [1:0]  D_GRF_rt_ForwardSrc,
  output logic [1:0]  E_GRF_rs_ForwardSrc,
  output logic [1:0]  E_GRF_rt_ForwardSrc,
  output logic [1:0]  M_GRF_rt_ForwardSrc,
  output logic [15:0] stall_cnt
);

  localparam logic [1:0]  TUSE_NONE = 2'd3;
  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  // D forward select encodings
  localparam logic [1:0] D_SEL_GRF = 2'd0;
  localparam logic [1:0] D_SEL_M   = 2'd1;
  localparam logic [1:0] D_SEL_E   = 2'd2;
  // E forward select encodings
  localparam logic [1:0] E_SEL_REG = 2'd0;
  localparam logic [1:0] E_SEL_W   = 2'd1;
  localparam logic [1:0] E_SEL_M   = 2'd2;
  // M forward select encodings
  localparam logic [1:0] M_SEL_REG = 2'd0;
  localparam logic [1:0] M_SEL_W   = 2'd1;

  // ---------------------------------------------------------------------------
  // Stage records
  // ---------------------------------------------------------------------------
  logic [4:0]  e_rs_reg,   e_rs_next;
  logic [4:0]  e_rt_reg,   e_rt_next;
  logic [4:0]  e_dst_reg,  e_dst_next;
  logic [1:0]  e_tnew_reg, e_tnew_next;
  logic [4:0]  m_rt_reg,   m_rt_next;
  logic [4:0]  m_dst_reg,  m_dst_next;
  logic [1:0]  m_tnew_reg, m_tnew_next;
  logic [4:0]  w_dst_reg,  w_dst_next;
  logic [15:0] stall_cnt_reg, stall_cnt_next;

  // ---------------------------------------------------------------------------
  // Per-operand views. Index 0 is rs and index 1 is rt, so the two operand
  // paths come from a single generate body.
  // ---------------------------------------------------------------------------
  logic [4:0] d_src  [2];
  logic [1:0] d_tuse [2];
  logic [4:0] e_src  [2];
  logic [1:0] d_fwd  [2];
  logic [1:0] e_fwd  [2];

  logic [1:0] d_need;      // operand is actually consumed by D
  logic [1:0] d_e_hit;     // E record writes this D operand
  logic [1:0] d_m_hit;     // M record writes this D operand
  logic [1:0] d_haz;       // operand not ready in time
  logic [1:0] e_m_hit;     // M record writes this E operand
  logic [1:0] e_w_hit;     // W record writes this E operand

  logic data_stall;
  logic md_stall;
  logic e_load;

  assign d_src[0]  = d_rs;
  assign d_src[1]  = d_rt;
  assign d_tuse[0] = d_tuse_rs;
  assign d_tuse[1] = d_tuse_rt;
  assign e_src[0]  = e_rs_reg;
  assign e_src[1]  = e_rt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      // Register 0 is hard-wired. Excluding it here means that bubbles
      // (dst = 0) never match any operand.
      assign d_need[gi]  = d_valid && (d_tuse[gi] != TUSE_NONE) && (d_src[gi] != REG_ZERO);
      assign d_e_hit[gi] = (d_src[gi] != REG_ZERO) && (e_dst_reg == d_src[gi]);
      assign d_m_hit[gi] = (d_src[gi] != REG_ZERO) && (m_dst_reg == d_src[gi]);

      // The result arrives later than the operand is consumed. Any producer
      // in flight can cause this, not only the nearest one.
      assign d_haz[gi] = d_need[gi] &&
                         ((d_e_hit[gi] && (e_tnew_reg > d_tuse[gi])) ||
                          (d_m_hit[gi] && (m_tnew_reg > d_tuse[gi])));

      // Only the nearest producer may forward. If that producer is not ready
      // yet, an older value further down the pipe is stale, so the select
      // falls back to GRF. The stall logic holds D until the value is ready.
      always_comb begin
        d_fwd[gi] = D_SEL_GRF;
        if (reset) begin
          if (d_e_hit[gi]) begin
            d_fwd[gi] = (e_tnew_reg == 2'd0) ? D_SEL_E : D_SEL_GRF;
          end else if (d_m_hit[gi]) begin
            d_fwd[gi] = (m_tnew_reg == 2'd0) ? D_SEL_M : D_SEL_GRF;
          end
        end
      end

      assign e_m_hit[gi] = (e_src[gi] != REG_ZERO) && (m_dst_reg == e_src[gi]) &&
                           (m_tnew_reg == 2'd0);
      assign e_w_hit[gi] = (e_src[gi] != REG_ZERO) && (w_dst_reg == e_src[gi]);

      // The younger M result wins over W.
      always_comb begin
        e_fwd[gi] = E_SEL_REG;
        if (reset) begin
          if (e_m_hit[gi]) begin
            e_fwd[gi] = E_SEL_M;
          end else if (e_w_hit[gi]) begin
            e_fwd[gi] = E_SEL_W;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stall decision
  // ---------------------------------------------------------------------------
  assign data_stall = |d_haz;

  // The mult/div stall holds for as long as the unit reports activity. It has
  // no timeout: a long divide simply keeps D frozen.
  assign md_stall = d_valid && d_md && (e_busy || e_start);

  assign stall = reset && (data_stall || md_stall);

  assign D_GRF_rs_ForwardSrc = d_fwd[0];
  assign D_GRF_rt_ForwardSrc = d_fwd[1];
  assign E_GRF_rs_ForwardSrc = e_fwd[0];
  assign E_GRF_rt_ForwardSrc = e_fwd[1];

  always_comb begin
    M_GRF_rt_ForwardSrc = M_SEL_REG;
    if (reset && (m_rt_reg != REG_ZERO) && (w_dst_reg == m_rt_reg)) begin
      M_GRF_rt_ForwardSrc = M_SEL_W;
    end
  end

  assign stall_cnt = stall_cnt_reg;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign e_load = !stall && d_valid;

  always_comb begin
    // E takes the D instruction, or a bubble when D stalls or is empty.
    e_rs_next   = e_load ? d_rs   : REG_ZERO;
    e_rt_next   = e_load ? d_rt   : REG_ZERO;
    e_dst_next  = e_load ? d_dst  : REG_ZERO;
    e_tnew_next = e_load ? d_tnew : 2'd0;

    // M and W advance every cycle. The remaining latency counts down by one
    // stage and stops at zero.
    m_rt_next   = e_rt_reg;
    m_dst_next  = e_dst_reg;
    m_tnew_next = (e_tnew_reg == 2'd0) ? 2'd0 : (e_tnew_reg - 2'd1);
    w_dst_next  = m_dst_reg;

    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != CNT_MAX)) begin
      stall_cnt_next = stall_cnt_reg + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset drops every pending producer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      e_rs_reg      <= REG_ZERO;
      e_rt_reg      <= REG_ZERO;
      e_dst_reg     <= REG_ZERO;
      e_tnew_reg    <= 2'd0;
      m_rt_reg      <= REG_ZERO;
      m_dst_reg     <= REG_ZERO;
      m_tnew_reg    <= 2'd0;
      w_dst_reg     <= REG_ZERO;
      stall_cnt_reg <= 16'd0;
    end else begin
      e_rs_reg      <= e_rs_next;
      e_rt_reg      <= e_rt_next;
      e_dst_reg     <= e_dst_next;
      e_tnew_reg    <= e_tnew_next;
      m_rt_reg      <= m_rt_next;
      m_dst_reg     <= m_dst_next;
      m_tnew_reg    <= m_tnew_next;
      w_dst_reg     <= w_dst_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

endmodule

// File: tb/tb_hazard_sched.sv
// -----------------------------------------------------------------------------
// tb_hazard_sched
//
// Self-checking bench for hazard_sched.
//
// The bench keeps a behavioural model of the pipeline. Each in-flight
// instruction is held as issued: its registers and its latency at issue.
// Each instruction also has an age: 0 in E, 1 in M and 2 in W. The remaining
// latency is derived as max(tnew - age, 0).
//
// One compare process checks every DUT output against the model on every
// cycle. The directed scenarios below also check hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_hazard_sched;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [1:0]  d_tuse_rs;
  logic [1:0]  d_tuse_rt;
  logic [4:0]  d_dst;
  logic [1:0]  d_tnew;
  logic        d_md;
  logic        e_start;
  logic        e_busy;
  logic        stall;
  logic [1:0]  D_GRF_rs_ForwardSrc;
  logic [1:0]  D_GRF_rt_ForwardSrc;
  logic [1:0]  E_GRF_rs_ForwardSrc;
  logic [1:0]  E_GRF_rt_ForwardSrc;
  logic [1:0]  M_GRF_rt_ForwardSrc;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  hazard_sched dut (
    .clk                 (clk),
    .reset               (reset),
    .d_valid             (d_valid),
    .d_rs                (d_rs),
    .d_rt                (d_rt),
    .d_tuse_rs           (d_tuse_rs),
    .d_tuse_rt           (d_tuse_rt),
    .d_dst               (d_dst),
    .d_tnew              (d_tnew),
    .d_md                (d_md),
    .e_start             (e_start),
    .e_busy              (e_busy),
    .stall               (stall),
    .D_GRF_rs_ForwardSrc (D_GRF_rs_ForwardSrc),
    .D_GRF_rt_ForwardSrc (D_GRF_rt_ForwardSrc),
    .E_GRF_rs_ForwardSrc (E_GRF_rs_ForwardSrc),
    .E_GRF_rt_ForwardSrc (E_GRF_rt_ForwardSrc),
    .M_GRF_rt_ForwardSrc (M_GRF_rt_ForwardSrc),
    .stall_cnt           (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Comparison helper
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp,
                     input bit quiet);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end else if (!quiet) begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: instructions in flight, indexed by age (0=E,1=M,2=W)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    int         tnew;
  } rec_t;

  rec_t pipe [3];
  int   mcnt;

  function automatic rec_t empty_rec();
    rec_t r;
    r.rs = 5'd0; r.rt = 5'd0; r.dst = 5'd0; r.tnew = 0;
    return r;
  endfunction

  function automatic int rem(input int age);
    int r;
    r = pipe[age].tnew - age;
    return (r > 0) ? r : 0;
  endfunction

  function automatic bit hazard(input logic [4:0] r, input logic [1:0] tuse);
    if (!d_valid || tuse == 2'd3 || r == 5'd0) return 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (pipe[k].dst == r && rem(k) > int'(tuse)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    if (!reset) return 1'b0;
    return hazard(d_rs, d_tuse_rs) || hazard(d_rt, d_tuse_rt) ||
           (d_valid && d_md && (e_busy || e_start));
  endfunction

  function automatic logic [1:0] exp_dsel(input logic [4:0] r);
    if (!reset || r == 5'd0) return 2'd0;
    if (pipe[0].dst == r) return (rem(0) == 0) ? 2'd2 : 2'd0;
    if (pipe[1].dst == r) return (rem(1) == 0) ? 2'd1 : 2'd0;
    return 2'd0;
  endfunction

  function automatic logic [1:0] exp_esel(input logic [4:0] r);
    if (!reset || r == 5'd0) return 2'd0;
    if (pipe[1].dst == r && rem(1) == 0) return 2'd2;
    if (pipe[2].dst == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] exp_msel();
    if (!reset || pipe[1].rt == 5'd0) return 2'd0;
    return (pipe[2].dst == pipe[1].rt) ? 2'd1 : 2'd0;
  endfunction

  task automatic model_edge();
    bit s;
    s = exp_stall();
    if (!reset) begin
      for (int k = 0; k < 3; k++) pipe[k] = empty_rec();
      mcnt = 0;
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (!s && d_valid) begin
        pipe[0].rs   = d_rs;
        pipe[0].rt   = d_rt;
        pipe[0].dst  = d_dst;
        pipe[0].tnew = int'(d_tnew);
      end else begin
        pipe[0] = empty_rec();
      end
      if (s && mcnt < 65535) mcnt++;
    end
  endtask

  // Compare process: update the model on the edge, check at the falling edge.
  initial begin
    for (int k = 0; k < 3; k++) pipe[k] = empty_rec();
    mcnt = 0;
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("cyc stall",     16'(stall),               16'(exp_stall()),           1'b1);
      chk("cyc D_rs_sel",  16'(D_GRF_rs_ForwardSrc), 16'(exp_dsel(d_rs)),        1'b1);
      chk("cyc D_rt_sel",  16'(D_GRF_rt_ForwardSrc), 16'(exp_dsel(d_rt)),        1'b1);
      chk("cyc E_rs_sel",  16'(E_GRF_rs_ForwardSrc), 16'(exp_esel(pipe[0].rs)),  1'b1);
      chk("cyc E_rt_sel",  16'(E_GRF_rt_ForwardSrc), 16'(exp_esel(pipe[0].rt)),  1'b1);
      chk("cyc M_rt_sel",  16'(M_GRF_rt_ForwardSrc), 16'(exp_msel()),            1'b1);
      chk("cyc stall_cnt", stall_cnt,                16'(mcnt),                  1'b1);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] trs, input logic [1:0] trt,
                       input logic [4:0] dst, input logic [1:0] tnew, input logic md);
    d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
    d_dst = dst; d_tnew = tnew; d_md = md;
  endtask

  task automatic idle();
    set_d(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b0);
    e_start = 1'b0;
    e_busy  = 1'b0;
  endtask

  // Advance one clock; inputs change shortly after the active edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    idle();
    tick();
    tick();
    #1;
    chk("reset stall",     16'(stall),               16'd0, 1'b0);
    chk("reset stall_cnt", stall_cnt,                16'd0, 1'b0);
    chk("reset E_rs_sel",  16'(E_GRF_rs_ForwardSrc), 16'd0, 1'b0);
    reset = 1'b1;
    tick();

    // Load-use: load dst=5 tnew=2, then a consumer of rs=5 with tuse=1.
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd2, 1'b0);
    tick();
    set_d(1'b1, 5'd5, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 1'b0);
    #1;
    chk("loaduse stall",     16'(stall),               16'd1, 1'b0);
    tick();
    #1;
    chk("loaduse release",   16'(stall),               16'd0, 1'b0);
    chk("loaduse D_rs_sel",  16'(D_GRF_rs_ForwardSrc), 16'd0, 1'b0);
    tick();
    idle();
    #1;
    chk("loaduse E_rs_sel",  16'(E_GRF_rs_ForwardSrc), 16'd1, 1'b0);
    drain();

    // ALU: dst=8 tnew=1, then a beq needing rt=8 with tuse=0.
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 1'b0);
    tick();
    set_d(1'b1, 5'd0, 5'd8, 2'd3, 2'd0, 5'd0, 2'd0, 1'b0);
    #1;
    chk("alu stall",         16'(stall),               16'd1, 1'b0);
    tick();
    #1;
    chk("alu release",       16'(stall),               16'd0, 1'b0);
    chk("alu D_rt_sel",      16'(D_GRF_rt_ForwardSrc), 16'd1, 1'b0);
    tick();
    drain();

    // SetWord: lui dst=3 tnew=0, then a consumer of rs=3 with tuse=0.
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd0, 1'b0);
    tick();
    set_d(1'b1, 5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    #1;
    chk("setword stall",     16'(stall),               16'd0, 1'b0);
    chk("setword D_rs_sel",  16'(D_GRF_rs_ForwardSrc), 16'd2, 1'b0);
    tick();
    drain();

    // Mult/div: start pulse then five busy cycles with mfhi waiting in D.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      e_start = (i == 0);
      e_busy  = (i != 0);
      #1;
      chk($sformatf("md stall c%0d", i), 16'(stall), 16'd1, 1'b0);
      tick();
    end
    e_start = 1'b0;
    e_busy  = 1'b0;
    #1;
    chk("md release",        16'(stall),               16'd0, 1'b0);
    chk("md stall_cnt",      stall_cnt,                16'd6, 1'b0);
    tick();
    drain();

    // Priority: three producers of r9 stacked in E, M and W.
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd0, 1'b0);
    tick();
    set_d(1'b1, 5'd0, 5'd9, 2'd3, 2'd3, 5'd9, 2'd0, 1'b0);
    #1;
    chk("prio issue2 stall", 16'(stall),               16'd0, 1'b0);
    tick();
    set_d(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 5'd9, 2'd1, 1'b0);
    #1;
    chk("prio issue3 stall", 16'(stall),               16'd0, 1'b0);
    tick();
    set_d(1'b1, 5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    #1;
    chk("prio stall",        16'(stall),               16'd1, 1'b0);
    chk("prio D_rs_sel",     16'(D_GRF_rs_ForwardSrc), 16'd0, 1'b0);
    chk("prio E_rs_sel",     16'(E_GRF_rs_ForwardSrc), 16'd2, 1'b0);
    chk("prio E_rt_sel r0",  16'(E_GRF_rt_ForwardSrc), 16'd0, 1'b0);
    chk("prio M_rt_sel",     16'(M_GRF_rt_ForwardSrc), 16'd1, 1'b0);
    set_d(1'b1, 5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    #1;
    chk("zero stall",        16'(stall),               16'd0, 1'b0);
    chk("zero D_rs_sel",     16'(D_GRF_rs_ForwardSrc), 16'd0, 1'b0);
    drain();

    // Reset mid-stall: build stall_cnt=40 and E.dst=7, then pulse reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1'b1);
    e_busy = 1'b1;
    repeat (40) tick();
    e_busy = 1'b0;
    #1;
    chk("rstcase md release", 16'(stall),              16'd0, 1'b0);
    tick();
    set_d(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd7, 2'd2, 1'b0);
    tick();
    set_d(1'b1, 5'd7, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 1'b0);
    #1;
    chk("rstcase stall_cnt",  stall_cnt,               16'd40, 1'b0);
    chk("rstcase stall",      16'(stall),              16'd1,  1'b0);
    reset = 1'b0;
    #1;
    chk("rstlow stall",       16'(stall),              16'd0,  1'b0);
    chk("rstlow D_rs_sel",    16'(D_GRF_rs_ForwardSrc), 16'd0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("postrst stall_cnt",  stall_cnt,               16'd0,  1'b0);
    chk("postrst stall r7",   16'(stall),              16'd0,  1'b0);
    chk("postrst D_rs_sel",   16'(D_GRF_rs_ForwardSrc), 16'd0, 1'b0);
    chk("postrst E_rs_sel",   16'(E_GRF_rs_ForwardSrc), 16'd0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_sched.md
HAZARD_SCHED -- requirements
Module: hazard_sched

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low. Ports are named clk and reset.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  synchronous reset, active-low.
- d_valid  in  1  D stage holds a real instruction.
- d_rs, d_rt  in  5 each  D source register numbers.
- d_tuse_rs, d_tuse_rt  in  2 each  cycles until the operand is consumed; 3 = operand unused.
- d_dst  in  5  D destination register; 0 = no write.
- d_tnew  in  2  result latency measured at E entry: 0 = E SetWord, 1 = M CalcResult, 2 = W DMRD.
- d_md  in  1  D instruction uses the mult/div unit.
- e_start, e_busy  in  1 each  mult/div start pulse and busy flag.
- stall  out  1  freeze F/D, bubble E.
- D_GRF_rs_ForwardSrc, D_GRF_rt_ForwardSrc  out  2 each  0 = GRF, 1 = M_CalcResult, 2 = E_SetWordResult.
- E_GRF_rs_ForwardSrc, E_GRF_rt_ForwardSrc  out  2 each  0 = E reg, 1 = W_RegData, 2 = M_CalcResult.
- M_GRF_rt_ForwardSrc  out  2  0 = M reg, 1 = W_RegData.
- stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-003 SHALL keep internal stage records: E {rs, rt, dst, tnew}, M {rt, dst, tnew}, W {dst}.
REQ-004 On each rising edge with reset high, E SHALL load D info when stall=0 and d_valid=1. Otherwise E SHALL load a bubble: dst=0, tnew=0, rs=rt=0.
REQ-005 On each rising edge with reset high, M SHALL load E with tnew = max(E.tnew-1, 0), and W SHALL load M.dst.
REQ-006 The operand for rs SHALL be considered needed iff d_valid=1, d_tuse_rs≠3 and d_rs≠0. The same rule applies to rt.
REQ-007 A data stall SHALL occur iff a needed operand r satisfies either (E.dst==r and E.tnew>tuse) or (M.dst==r and M.tnew>tuse).
REQ-008 A mult/div stall SHALL occur iff d_valid=1, d_md=1, and (e_busy=1 or e_start=1).
REQ-009 stall SHALL be the OR of the data stall and the mult/div stall, computed combinationally from the current state and inputs.
REQ-010 D forward select SHALL be chosen from the nearest producer only:
- if E.dst==r≠0: select 2 when E.tnew==0, else 0;
- else if M.dst==r≠0: select 1 when M.tnew==0, else 0;
- else 0.
REQ-011 E forward select for E.rs/E.rt SHALL be:
- 2 if M.dst==r≠0 and M.tnew==0;
- else 1 if W.dst==r≠0;
- else 0.
The M match takes priority over W.
REQ-012 M_GRF_rt_ForwardSrc SHALL be 1 iff W.dst==M.rt≠0, else 0.
REQ-013 Register 0 SHALL never produce a stall or a non-zero forward select.
REQ-014 stall_cnt SHALL increment by 1 on each edge where stall=1 and reset is high, and SHALL hold at 16'hFFFF once saturated.
REQ-015 A stall SHALL NOT alter M or W advancement. Outstanding producers SHALL drain and clear the stall within at most 2 cycles.
REQ-016 A mult/div stall SHALL persist for the whole busy period, without bound, and SHALL release on the first cycle where e_busy=0 and e_start=0.

Reset
REQ-017 On an edge with reset low, all stage records SHALL clear (dst=0, tnew=0, rs=rt=0) and stall_cnt SHALL become 0.
REQ-018 While reset is low, stall and all forward selects SHALL be driven 0, regardless of the other inputs.
REQ-019 Reset asserted mid-stall SHALL discard all pending producers. The first cycle after reset deasserts SHALL produce stall=0 unless d_md with e_busy applies.

Verification
REQ-020 Load-use case: load with dst=5, tnew=2 in E; D uses rs=5 with tuse=1.
- stall=1 for 1 cycle;
- next cycle M.tnew=1>1 is false, so stall=0 and D_GRF_rs_ForwardSrc=0;
- following cycle E_GRF_rs_ForwardSrc=1.
REQ-021 ALU case: ALU with dst=8, tnew=1 in E; D beq needs rt=8 with tuse=0 -> stall=1 for 1 cycle, then D_GRF_rt_ForwardSrc=1.
REQ-022 SetWord case: lui-type with dst=3, tnew=0 in E; D needs rs=3 with tuse=0 -> stall=0 and D_GRF_rs_ForwardSrc=2.
REQ-023 Mult/div case: e_start=1, then e_busy=1 for 5 cycles, with D mfhi (d_md=1) -> stall=1 for 6 cycles and stall_cnt=6.
REQ-024 Priority and zero-register case:
- E.dst=M.dst=W.dst=9 with E.tnew=1 and M.tnew=0 -> D select=0 with stall=1, and E select=2;
- d_rs=0 -> no stall, select 0.
REQ-025 Reset case: reset low for 1 edge while stall_cnt=40 and E.dst=7 -> stall_cnt=0, all selects 0, and no stall on reg 7.
